vga_sync_decoder: RTL and testbench

Receive-side counterpart of the bouncing-logo VGA generator. The block samples the 8-bit TinyVGA PMOD pin bundle and recovers pixel coordinates and 6-bit colour. It measures line and frame timing, runs a lock state machine, and publishes a per-frame pixel signature. Its uses are on-chip loopback self-test and the verification bench's display checker.

---
 rtl/vga_sync_decoder.sv | 192 +++++++++++++++++++
 tb/tb_vga_sync_decoder.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/vga_sync_decoder.sv
// Receive-side VGA decoder: recovers pixel coordinates and colour from the TinyVGA
// PMOD pin bundle, measures line/frame timing, tracks lock and signs each clean frame.
module vga_sync_decoder #(
    parameter int H_ACTIVE        = 640,
    parameter int H_TOTAL         = 800,
    parameter int H_START         = 144,
    parameter int V_ACTIVE        = 480,
    parameter int V_TOTAL         = 525,
    parameter int V_START         = 35,
    parameter bit SYNC_ACTIVE_LOW = 1'b1,
    parameter int LOCK_FRAMES     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  vga_in,
    output logic [5:0]  rgb,
    output logic [9:0]  px_x,
    output logic [9:0]  px_y,
    output logic        px_valid,
    output logic        frame_start,
    output logic        locked,
    output logic        timing_err,
    output logic        blank_err,
    output logic [9:0]  line_len,
    output logic [9:0]  frame_lines,
    output logic [15:0] frame_sig,
    output logic        sig_valid
);

    typedef enum logic [1:0] {SEARCH, TRACK, LOCKED} state_t;

    localparam logic [10:0] H_LO     = 11'(H_START);
    localparam logic [10:0] H_HI     = 11'(H_START + H_ACTIVE);
    localparam logic [10:0] V_LO     = 11'(V_START);
    localparam logic [10:0] V_HI     = 11'(V_START + V_ACTIVE);
    localparam logic [10:0] H_TOT_W  = 11'(H_TOTAL);
    localparam logic [9:0]  V_TOT_W  = 10'(V_TOTAL);
    localparam logic [9:0]  H_STRT_W = 10'(H_START);
    localparam logic [9:0]  V_STRT_W = 10'(V_START);
    localparam logic [7:0]  LOCK_W   = 8'(LOCK_FRAMES);
    localparam logic [9:0]  SAT      = '1;
    // Input register resets to idle sync levels so release does not fake an edge
    localparam logic [7:0]  IN_IDLE  = SYNC_ACTIVE_LOW ? 8'h88 : 8'h00;

    state_t      state, state_nxt;
    logic [7:0]  in_q;
    logic        hs_prev, vs_prev;
    logic [9:0]  hcnt, vline;
    logic [7:0]  gcnt, gcnt_nxt;
    logic [15:0] sig;
    logic        clean;

    logic        hs_act, vs_act, hs_edge, vs_edge;
    logic [5:0]  rgb_cur;
    logic [10:0] hcnt_inc;
    logic [9:0]  hcnt_nxt, vline_nxt;
    logic        active, pv_cur, blank_cur, hto;
    logic        line_bad, frame_bad, terr, publish, clean_nxt;
    logic [15:0] sig_nxt;

    always_comb begin
        hs_act   = in_q[7] ^ SYNC_ACTIVE_LOW;
        vs_act   = in_q[3] ^ SYNC_ACTIVE_LOW;
        hs_edge  = hs_act & ~hs_prev;
        vs_edge  = vs_act & ~vs_prev;
        rgb_cur  = {in_q[0], in_q[4], in_q[1], in_q[5], in_q[2], in_q[6]};

        // hcnt/vline hold the position of the previous sample; *_nxt is in_q's position
        hcnt_inc = {1'b0, hcnt} + 11'd1;
        if (hs_edge)
            hcnt_nxt = '0;
        else if (hcnt == SAT)
            hcnt_nxt = SAT;
        else
            hcnt_nxt = hcnt_inc[9:0];

        if (vs_edge)
            vline_nxt = '0;
        else if (hs_edge && vline != SAT)
            vline_nxt = vline + 10'd1;
        else
            vline_nxt = vline;

        active = ({1'b0, hcnt_nxt} >= H_LO) && ({1'b0, hcnt_nxt} < H_HI) &&
                 ({1'b0, vline_nxt} >= V_LO) && ({1'b0, vline_nxt} < V_HI);
        pv_cur    = active && (state == LOCKED);
        blank_cur = (state != SEARCH) && !active && (rgb_cur != '0);
        hto       = (hcnt_nxt == SAT) && (hcnt != SAT);
        line_bad  = hs_edge && (hcnt_inc != H_TOT_W);
        frame_bad = vs_edge && (vline != V_TOT_W);
    end

    always_comb begin
        state_nxt = state;
        gcnt_nxt  = gcnt;
        terr      = 1'b0;
        case (state)
            SEARCH: begin
                if (vs_edge) begin
                    state_nxt = TRACK;
                    gcnt_nxt  = '0;
                end
            end
            TRACK, LOCKED: begin
                if (line_bad || frame_bad) begin
                    terr      = 1'b1;
                    gcnt_nxt  = '0;
                    state_nxt = TRACK;
                end else if (vs_edge && state == TRACK) begin
                    gcnt_nxt = gcnt + 8'd1;
                    if (gcnt + 8'd1 == LOCK_W)
                        state_nxt = LOCKED;
                end
            end
            default: state_nxt = SEARCH;
        endcase
        if (hto) begin
            if (state != SEARCH)
                terr = 1'b1;
            state_nxt = SEARCH;
        end
    end

    always_comb begin
        publish = vs_edge && clean && !terr;
        if (terr || state_nxt != LOCKED)
            clean_nxt = 1'b0;
        else if (vs_edge && state == LOCKED)
            clean_nxt = 1'b1;
        else
            clean_nxt = clean;

        if (vs_edge)
            sig_nxt = '0;
        else if (pv_cur)
            sig_nxt = {sig[14:0], sig[15]} ^ {10'b0, rgb_cur};
        else
            sig_nxt = sig;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            in_q        <= IN_IDLE;
            hs_prev     <= 1'b0;
            vs_prev     <= 1'b0;
            hcnt        <= '0;
            vline       <= '0;
            state       <= SEARCH;
            gcnt        <= '0;
            sig         <= '0;
            clean       <= 1'b0;
            rgb         <= '0;
            px_x        <= '0;
            px_y        <= '0;
            px_valid    <= 1'b0;
            frame_start <= 1'b0;
            locked      <= 1'b0;
            timing_err  <= 1'b0;
            blank_err   <= 1'b0;
            line_len    <= '0;
            frame_lines <= '0;
            frame_sig   <= '0;
            sig_valid   <= 1'b0;
        end else begin
            in_q        <= vga_in;
            hs_prev     <= hs_act;
            vs_prev     <= vs_act;
            hcnt        <= hcnt_nxt;
            vline       <= vline_nxt;
            state       <= state_nxt;
            gcnt        <= gcnt_nxt;
            sig         <= sig_nxt;
            clean       <= clean_nxt;
            rgb         <= rgb_cur;
            px_x        <= active ? hcnt_nxt - H_STRT_W : '0;
            px_y        <= active ? vline_nxt - V_STRT_W : '0;
            px_valid    <= pv_cur;
            frame_start <= vs_edge;
            locked      <= (state_nxt == LOCKED);
            timing_err  <= terr;
            blank_err   <= blank_cur;
            sig_valid   <= publish;
            if (hs_edge)
                line_len <= (hcnt == SAT) ? SAT : hcnt_inc[9:0];
            if (vs_edge)
                frame_lines <= vline;
            if (publish)
                frame_sig <= sig;
        end
    end

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Scoreboard bench for vga_sync_decoder on a reduced 64x20-clock raster with a
// 32x12 active window; expectations are queued at drive time and checked by a monitor.
module tb_vga_sync_decoder;

    localparam int HA = 32, HT = 64, HS0 = 40, HSW = 8, HST = HT - HS0;
    localparam int VA = 12, VT = 20, VS0 = 14, VST = VT - VS0;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  vga_in;
    logic [5:0]  rgb;
    logic [9:0]  px_x, px_y, line_len, frame_lines;
    logic        px_valid, frame_start, locked, timing_err, blank_err, sig_valid;
    logic [15:0] frame_sig;

    always #5 clk = ~clk;

    vga_sync_decoder #(
        .H_ACTIVE(HA), .H_TOTAL(HT), .H_START(HST),
        .V_ACTIVE(VA), .V_TOTAL(VT), .V_START(VST),
        .SYNC_ACTIVE_LOW(1'b1), .LOCK_FRAMES(2)
    ) dut (
        .clk(clk), .reset(reset), .vga_in(vga_in), .rgb(rgb),
        .px_x(px_x), .px_y(px_y), .px_valid(px_valid), .frame_start(frame_start),
        .locked(locked), .timing_err(timing_err), .blank_err(blank_err),
        .line_len(line_len), .frame_lines(frame_lines),
        .frame_sig(frame_sig), .sig_valid(sig_valid)
    );

    typedef enum int {K_RST, K_PX, K_LOCK, K_LEN, K_FL, K_SIG, K_TERR, K_BLANK, K_FS} kind_t;
    typedef struct {
        int unsigned cyc;
        kind_t       kind;
        logic [15:0] a;
        logic [15:0] b;
    } exp_t;

    exp_t        sb[$];
    int unsigned cyc = 0;
    int          n_checks = 0;
    int          n_pass = 0;
    int          kill_left = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] pins(input logic hs, input logic vs, input logic [5:0] c);
        return {hs, c[0], c[2], c[4], vs, c[1], c[3], c[5]};
    endfunction

    task automatic push(input kind_t k, input int unsigned dly, input logic [15:0] a, input logic [15:0] b);
        exp_t e;
        e.cyc = cyc + dly; e.kind = k; e.a = a; e.b = b;
        sb.push_back(e);
    endtask

    task automatic px(input logic v, input int x, input int y);
        push(K_PX, 2, {5'b0, v, 10'(x)}, 16'(y));
    endtask

    task automatic drive(input logic hs, input logic vs, input logic [5:0] c);
        @(posedge clk);
        #1 vga_in = pins(hs, vs, c);
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
    endtask

    always @(negedge clk) begin : monitor
        logic e_terr, e_blank, e_sig, e_fs;
        e_terr = 1'b0; e_blank = 1'b0; e_sig = 1'b0; e_fs = 1'b0;
        for (int i = int'(sb.size()) - 1; i >= 0; i--) begin
            if (sb[i].cyc == cyc) begin
                case (sb[i].kind)
                    K_RST: begin
                        chk("reset_outputs", 64'({rgb, px_x, px_y, px_valid, frame_start, locked,
                                                  timing_err, blank_err, sig_valid}), 64'd0);
                        chk("reset_counters", 64'({line_len, frame_lines, frame_sig}), 64'd0);
                    end
                    K_PX:    chk("pixel", 64'({px_valid, px_x, px_y}),
                                 64'({sb[i].a[10], sb[i].a[9:0], sb[i].b[9:0]}));
                    K_LOCK:  chk("locked", 64'(locked), 64'(sb[i].a[0]));
                    K_LEN:   chk("line_len", 64'(line_len), 64'(sb[i].a[9:0]));
                    K_FL:    chk("frame_lines", 64'(frame_lines), 64'(sb[i].a[9:0]));
                    K_SIG: begin
                        chk("frame_sig", 64'({sig_valid, frame_sig}), 64'({1'b1, sb[i].a}));
                        e_sig = 1'b1;
                    end
                    K_TERR:  e_terr = 1'b1;
                    K_BLANK: e_blank = 1'b1;
                    K_FS:    e_fs = 1'b1;
                    default: ;
                endcase
                sb.delete(i);
            end else if (sb[i].cyc < cyc) begin
                n_checks++;
                $display("FAIL missed_event kind %0d due %0d now %0d", sb[i].kind, sb[i].cyc, cyc);
                sb.delete(i);
            end
        end
        if (timing_err || e_terr)  chk("timing_err_pulse", 64'(timing_err), 64'(e_terr));
        if (blank_err || e_blank)  chk("blank_err_pulse", 64'(blank_err), 64'(e_blank));
        if (sig_valid || e_sig)    chk("sig_valid_pulse", 64'(sig_valid), 64'(e_sig));
        if (frame_start || e_fs)   chk("frame_start_pulse", 64'(frame_start), 64'(e_fs));
    end

    task automatic run_frame(input int f);
        for (int ln = 0; ln < VT; ln++) begin
            int   len;
            logic line_kill;
            len = (f == 7 && ln == 5) ? HT + 1 : HT;
            line_kill = 1'b0;
            for (int h = 0; h < len; h++) begin
                logic [5:0] c;
                logic       hs_pin, vs_pin;
                c = '0;
                if (f == 4 && ln == 0 && h == 0) c = 6'h3F;
                if (f == 6 && ln == 3 && h == 36) c = 6'h01;
                if (h == HS0 && kill_left > 0) begin
                    line_kill = 1'b1;
                    kill_left--;
                end
                vs_pin = !(ln == VS0 || ln == VS0 + 1);
                hs_pin = !(h >= HS0 && h < HS0 + HSW) || line_kill;
                drive(hs_pin, vs_pin, c);

                if (ln == VS0 && h == 0) begin
                    push(K_FS, 2, 0, 0);
                    case (f)
                        0:  begin push(K_FL, 2, 16'd14, 0); push(K_LOCK, 2, 0, 0); end
                        1:  push(K_FL, 2, 16'd20, 0);
                        2, 8, 12: begin
                            push(K_LOCK, 1, 0, 0);
                            push(K_LOCK, 2, 1, 0);
                            if (f == 2) push(K_LEN, 2, 16'd64, 0);
                        end
                        4:  push(K_SIG, 2, 16'h801F, 0);
                        5, 6: push(K_SIG, 2, 16'h0000, 0);
                        10: push(K_FL, 2, 16'd3, 0);
                        default: ;
                    endcase
                end
                if (ln == 0 && h == 0) begin
                    if (f == 2 || f == 8 || f == 10 || f == 11) px(1'b0, 0, 0);
                    if (f == 3 || f == 13) px(1'b1, 0, 0);
                end
                if (f == 3) begin
                    if (ln == 0 && h == 31)  px(1'b1, 31, 0);
                    if (ln == 0 && h == 32)  px(1'b0, 0, 0);
                    if (ln == 11 && h == 31) px(1'b1, 31, 11);
                    if (ln == 12 && h == 0)  px(1'b0, 0, 0);
                end
                if (f == 13 && ln == 5 && h == 7) px(1'b1, 7, 5);
                if (f == 6 && ln == 3 && h == 36) begin
                    push(K_BLANK, 2, 0, 0);
                    push(K_LOCK, 2, 1, 0);
                end
                if (f == 7 && ln == 6 && h == HS0) begin
                    push(K_TERR, 2, 0, 0);
                    push(K_LEN, 2, 16'd65, 0);
                    push(K_LOCK, 2, 0, 0);
                end
                // Last hsync before a 17-line gap: hcnt saturates 1023 samples later
                if (f == 9 && ln == VS0 && h == HS0) begin
                    push(K_TERR, 1025, 0, 0);
                    push(K_LOCK, 1025, 0, 0);
                    kill_left = 17;
                end
            end
        end
    endtask

    initial begin
        reset  = 1'b1;
        vga_in = pins(1'b1, 1'b1, 6'h00);
        repeat (3) drive(1'b1, 1'b1, 6'h00);
        push(K_RST, 1, 0, 0);
        push(K_RST, 2, 0, 0);
        drive(1'b1, 1'b1, 6'h00);
        reset = 1'b0;
        for (int f = 0; f < 14; f++) run_frame(f);
        repeat (4) drive(1'b1, 1'b1, 6'h00);
        @(negedge clk);
        while (sb.size() != 0) begin
            n_checks++;
            $display("FAIL unchecked_event kind %0d due %0d", sb[0].kind, sb[0].cyc);
            void'(sb.pop_front());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
